// File: rtl/mult_arb_pkg.sv
// Shared defaults, state encoding and pointer sizing for the round-robin multiplier arbiter.
// MULT_ARB_PIPE2_EN adds the CALC2 state for a two-stage product.
package mult_arb_pkg;

    localparam int N_DEF = 24;
    localparam int R_DEF = 4;

    // A single requester still needs a one-bit pointer to keep the ports well formed.
    function automatic int ptr_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    localparam int PTR_W = ptr_width(R_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
`ifdef MULT_ARB_PIPE2_EN
        CALC2 = 3'd2,
`endif
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbitro.sv
// Round-robin winner selection: first active request at or above ptr, wrapping R-1 -> 0.
// Purely combinational; the caller registers the winner on its arbitration edge.
module rr_arbitro #(
    parameter int R  = 4,
    parameter int PW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic [R-1:0]  onehot
);

    logic [2*R-1:0] req_dbl;
    logic [R-1:0]   rot;
    logic [R:0]     below;
    logic [R-1:0]   first;
    logic [2*R-1:0] first_shl;
    logic [PW-1:0]  enc_chain [R+1];

    // Rotate so that ptr sits at bit 0, pick the lowest set bit, rotate back.
    assign req_dbl   = {req, req};
    assign rot       = req_dbl[ptr +: R];
    assign below[0]  = 1'b0;
    assign first_shl = {first, first} << ptr;
    assign onehot    = first_shl[2*R-1:R];

    assign enc_chain[0] = '0;
    assign winner       = enc_chain[R];

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_pick
            assign below[gi+1]     = below[gi] | rot[gi];
            assign first[gi]       = rot[gi] & ~below[gi];
            assign enc_chain[gi+1] = enc_chain[gi] | (onehot[gi] ? PW'(gi) : '0);
        end
    endgenerate

endmodule

// File: rtl/arbitro_multiplicador.sv
// R requesters share one registered N x N multiplier through a round-robin FSM.
// Define MULT_ARB_PIPE2_EN to add a second product stage (CALC2, one extra cycle of latency).
import mult_arb_pkg::*;

module arbitro_multiplicador #(
    parameter int N = N_DEF,
    parameter int R = R_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     req,
    input  logic [R*N-1:0]   op_a,
    input  logic [R*N-1:0]   op_b,
    output logic [R-1:0]     gnt,
    output logic [R-1:0]     done,
    output logic [2*N-1:0]   result,
    output logic             busy
);

    localparam int PW = ptr_width(R);

    state_t           state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    win_reg;
    logic [R-1:0]     gnt_reg;
    logic [R-1:0]     done_reg;
    logic [2*N-1:0]   result_reg;
    logic             busy_reg;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [2*N-1:0]   prod_reg;
`ifdef MULT_ARB_PIPE2_EN
    logic [2*N-1:0]   prod2_reg;
`endif
    logic [2*N-1:0]   prod_final;

    logic [PW-1:0]    win_idx;
    logic [R-1:0]     win_onehot;
    logic [PW-1:0]    ptr_next;
    logic [N-1:0]     a_slice [R];
    logic [N-1:0]     b_slice [R];

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_unpack
            assign a_slice[gi] = op_a[gi*N +: N];
            assign b_slice[gi] = op_b[gi*N +: N];
        end
    endgenerate

    rr_arbitro #(
        .R  (R),
        .PW (PW)
    ) u_rr (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (win_idx),
        .onehot (win_onehot)
    );

    assign ptr_next = (win_reg == PW'(R-1)) ? '0 : win_reg + PW'(1);

`ifdef MULT_ARB_PIPE2_EN
    assign prod_final = prod2_reg;
`else
    assign prod_final = prod_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            win_reg    <= '0;
            gnt_reg    <= '0;
            done_reg   <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            prod_reg   <= '0;
`ifdef MULT_ARB_PIPE2_EN
            prod2_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // Operands are captured here so later changes on op_a/op_b cannot reach the product.
                    if (|req) begin
                        win_reg   <= win_idx;
                        a_reg     <= a_slice[win_idx];
                        b_reg     <= b_slice[win_idx];
                        gnt_reg   <= win_onehot;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    prod_reg  <= {{N{1'b0}}, a_reg} * {{N{1'b0}}, b_reg};
`ifdef MULT_ARB_PIPE2_EN
                    state_reg <= CALC2;
`else
                    state_reg <= RESP;
`endif
                end
`ifdef MULT_ARB_PIPE2_EN
                CALC2: begin
                    prod2_reg <= prod_reg;
                    state_reg <= RESP;
                end
`endif
                RESP: begin
                    result_reg <= prod_final;
                    done_reg   <= gnt_reg;
                    gnt_reg    <= '0;
                    ptr_reg    <= ptr_next;
                    state_reg  <= DONE;
                end
                DONE: begin
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    gnt_reg   <= '0;
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign busy   = busy_reg;

endmodule
